// File: rtl/display_pkg.sv
// Shared types and helpers for the display time-sharing scheduler.
package display_pkg;
  localparam int DATA_W  = 32;
  localparam int MAX_SRC = 8;

  typedef enum logic {IDLE, HOLD} state_e;

  // Extracts the word of source idx from a bus zero-extended to MAX_SRC slots.
  function automatic logic [DATA_W-1:0] get_slot(input logic [MAX_SRC*DATA_W-1:0] bus,
                                                 input int unsigned idx);
    return bus[idx*DATA_W +: DATA_W];
  endfunction
endpackage

// File: rtl/display_scheduler_rr_arbiter.sv
// Combinational arbiter: round-robin from ptr, or fixed lowest-index priority
// when DISP_SCHED_PRIORITY_EN is defined.
module rr_arbiter
  import display_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] ptr,
  output logic [NUM_SRC-1:0]         grant,
  output logic [$clog2(NUM_SRC)-1:0] idx,
  output logic                       any_req
);
  localparam int IDX_W = $clog2(NUM_SRC);

  logic found;

  assign any_req = |req;

`ifdef DISP_SCHED_PRIORITY_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = IDX_W'(k);
      end
    end
  end
`else
  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = (int'(ptr) + k) % NUM_SRC;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end
`endif
endmodule

// File: rtl/display_scheduler.sv
// Time-shares the 32-bit display word between NUM_SRC requesters with a minimum
// hold time per grant. Define DISP_SCHED_PRIORITY_EN for fixed priority instead of round-robin.
module display_scheduler
  import display_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_SRC-1:0]           req,
  input  logic [NUM_SRC*DATA_W-1:0]    src_data,
  output logic [NUM_SRC-1:0]           ack,
  output logic [DATA_W-1:0]            disp_data,
  output logic [$clog2(NUM_SRC)-1:0]   disp_src,
  output logic                         busy
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int IDX_W = $clog2(NUM_SRC);

  state_e                    state_q;
  logic [DATA_W-1:0]         disp_data_q;
  logic [IDX_W-1:0]          disp_src_q;
  logic [NUM_SRC-1:0]        ack_q;
  logic                      busy_q;
  logic [CNT_W-1:0]          cnt_q;

  logic [MAX_SRC*DATA_W-1:0] src_ext;
  logic [IDX_W-1:0]          search_ptr;
  logic [NUM_SRC-1:0]        win_grant;
  logic [IDX_W-1:0]          win_idx;
  logic                      any_req;
  logic                      do_grant;

  assign src_ext = (MAX_SRC*DATA_W)'(src_data);

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .req     (req),
    .ptr     (search_ptr),
    .grant   (win_grant),
    .idx     (win_idx),
    .any_req (any_req)
  );

  // A new grant happens from IDLE or at expiry; there is no bubble between owners.
  assign do_grant = any_req && ((state_q == IDLE) || (cnt_q == '0));

`ifdef DISP_SCHED_PRIORITY_EN
  assign search_ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (do_grant) begin
      rr_ptr_q <= (win_idx == IDX_W'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  assign search_ptr = rr_ptr_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      disp_data_q <= '0;
      disp_src_q  <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ack_q <= '0;
      if (do_grant) begin
        state_q     <= HOLD;
        disp_data_q <= get_slot(src_ext, 32'(win_idx));
        disp_src_q  <= win_idx;
        ack_q       <= win_grant;
        busy_q      <= 1'b1;
        cnt_q       <= CNT_W'(HOLD_CYCLES - 1);
      end else if (state_q == HOLD) begin
        if (cnt_q != '0) begin
          // Owner refresh updates the word but never extends the hold window.
          cnt_q <= cnt_q - 1'b1;
          if (req[disp_src_q]) begin
            disp_data_q        <= get_slot(src_ext, 32'(disp_src_q));
            ack_q[disp_src_q]  <= 1'b1;
          end
        end else begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      end
    end
  end

  assign ack       = ack_q;
  assign disp_data = disp_data_q;
  assign disp_src  = disp_src_q;
  assign busy      = busy_q;
endmodule
